// File: rtl/sdram_word_adapter_pkg.sv
// sdram_word_adapter_pkg: shared states and the next-enabled-byte search for the word adapter.
package sdram_word_adapter_pkg;

    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SCAN    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT_RD = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // Lowest enabled byte at or above 'from'; 4 means none left.
    function automatic logic [2:0] next_byte(input logic [3:0] be, input logic [2:0] from);
        next_byte = 3'd4;
        for (int k = BYTES_PER_WORD - 1; k >= 0; k--)
            if (be[k] && 3'(k) >= from) next_byte = 3'(k);
    endfunction

endpackage

// File: rtl/sdram_word_adapter.sv
// sdram_word_adapter: splits 32-bit word requests with byte enables into byte accesses
// on the SDRAM controller port and gathers read bytes into one word response.
module sdram_word_adapter
    import sdram_word_adapter_pkg::*;
#(
    parameter int ADDR_DEPTH = 25,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_DEPTH-3:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_DEPTH-1:0] ctrl_addr,
    output logic [7:0]            ctrl_data_wr,
    output logic                  ctrl_wr,
    output logic                  ctrl_rd,
    input  logic                  ctrl_rdy,
    input  logic                  ctrl_val,
    input  logic [7:0]            ctrl_data_rd
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_DEPTH-3:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [2:0]            idx_q, idx_d;
    logic [31:0]           lane_q, lane_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [31:0]           rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        err_d   = err_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d = S_SCAN;
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                be_d    = req_be;
                idx_d   = 3'd0;
                lane_d  = 32'd0;
                err_d   = 1'b0;
            end
            S_SCAN: begin
                idx_d   = next_byte(be_q, idx_q);
                state_d = idx_d[2] ? S_DONE : S_ISSUE;
            end
            S_ISSUE: if (ctrl_rdy) begin
                timer_d = '0;
                idx_d   = we_q ? idx_q + 3'd1 : idx_q;
                state_d = we_q ? S_SCAN : S_WAIT_RD;
            end
            S_WAIT_RD: if (ctrl_val) begin
                lane_d[{idx_q[1:0], 3'b000} +: 8] = ctrl_data_rd;
                idx_d   = idx_q + 3'd1;
                state_d = S_SCAN;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                idx_d   = idx_q + 3'd1;
                state_d = S_SCAN;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                rdata_d = we_q ? rdata_q : lane_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready    = state_q == S_IDLE;
    assign resp_valid   = state_q == S_DONE && !we_q;
    assign resp_rdata   = resp_valid ? lane_q : rdata_q;
    assign resp_err     = resp_valid && err_q;
    assign ctrl_wr      = state_q == S_ISSUE && we_q;
    assign ctrl_rd      = state_q == S_ISSUE && !we_q;
    assign ctrl_addr    = {addr_q, idx_q[1:0]};
    assign ctrl_data_wr = wdata_q[{idx_q[1:0], 3'b000} +: 8];

endmodule

// File: tb/tb_sdram_word_adapter.sv
// tb_sdram_word_adapter: directed bench with a stub byte controller, a reference word
// memory and a response scoreboard for sdram_word_adapter.
module tb_sdram_word_adapter;

    localparam int AD = 25;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AD-3:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AD-1:0] ctrl_addr;
    logic [7:0]    ctrl_data_wr;
    logic          ctrl_wr;
    logic          ctrl_rd;
    logic          ctrl_rdy = 1'b1;
    logic          ctrl_val = 1'b0;
    logic [7:0]    ctrl_data_rd = '0;

    sdram_word_adapter #(.ADDR_DEPTH(AD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ctrl_addr(ctrl_addr), .ctrl_data_wr(ctrl_data_wr), .ctrl_wr(ctrl_wr),
        .ctrl_rd(ctrl_rd), .ctrl_rdy(ctrl_rdy), .ctrl_val(ctrl_val),
        .ctrl_data_rd(ctrl_data_rd)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;

    // Stub controller knobs, written only by the stimulus block.
    int   lat = 3;
    logic mute = 1'b0;
    int   busy_from = -1;
    int   busy_to = -1;
    int   inject_at = -1;

    // Stub controller state, written only by the stub.
    int            cyc = 0;
    int            cnt = 0;
    logic [AD-1:0] paddr = '0;
    logic [7:0]    mem [int];
    logic [AD:0]   log_q [$];
    int            stalls = 0;
    int            unstable = 0;
    logic          had_stall = 1'b0;
    logic [AD-1:0] stall_addr = '0;
    int            resp_cnt = 0;

    // Stub reacts half a cycle before the DUT samples its outputs.
    always @(negedge clk) begin
        cyc++;
        ctrl_rdy = !(cyc >= busy_from && cyc < busy_to);
        ctrl_val = 1'b0;
        if (cyc == inject_at) begin
            ctrl_val = 1'b1;
            ctrl_data_rd = 8'hEE;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                ctrl_val = 1'b1;
                ctrl_data_rd = mem.exists(int'(paddr)) ? mem[int'(paddr)] : 8'h00;
            end
        end
        if ((ctrl_rd || ctrl_wr) && !ctrl_rdy) begin
            stalls++;
            if (had_stall && ctrl_addr != stall_addr) unstable++;
            had_stall = 1'b1;
            stall_addr = ctrl_addr;
        end else begin
            had_stall = 1'b0;
        end
        if (ctrl_wr && ctrl_rdy) begin
            mem[int'(ctrl_addr)] = ctrl_data_wr;
            log_q.push_back({1'b1, ctrl_addr});
        end
        if (ctrl_rd && ctrl_rdy) begin
            log_q.push_back({1'b0, ctrl_addr});
            paddr = ctrl_addr;
            if (!mute) cnt = lat;
        end
        if (resp_valid) resp_cnt++;
    end

    logic [7:0]  ref_mem [int];
    logic [32:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [AD-3:0] a, input logic [31:0] d,
                        input logic [3:0] be);
        int n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AD-3:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        for (int k = 0; k < 4; k++)
            if (be[k]) ref_mem[int'(a) * 4 + k] = d[8*k +: 8];
        send(1'b1, a, d, be);
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        chk("write_done", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic do_read(input string tag, input logic [AD-3:0] a, input logic [3:0] be,
                           input logic timed_out);
        logic [31:0] w = '0;
        logic [32:0] e;
        int n = 0;
        for (int k = 0; k < 4; k++)
            if (be[k] && !timed_out) w[8*k +: 8] = ref_mem[int'(a) * 4 + k];
        exp_q.push_back({timed_out, w});
        send(1'b0, a, 32'd0, be);
        while (!resp_valid && n < 4 * (TO + 4) + 40) begin @(negedge clk); n++; end
        if (resp_valid) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, {32'd0, resp_rdata}, {32'd0, e[31:0]});
            chk({tag, "_err"}, {63'd0, resp_err}, {63'd0, e[32]});
            @(negedge clk);
        end else begin
            chk({tag, "_resp_timeout"}, {63'd0, resp_valid}, 64'd1);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_rvalid"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_rdata"}, {32'd0, resp_rdata}, 64'd0);
        chk({tag, "_rerr"}, {63'd0, resp_err}, 64'd0);
        chk({tag, "_rd_wr"}, {62'd0, ctrl_rd, ctrl_wr}, 64'd0);
        chk({tag, "_addr"}, {39'd0, ctrl_addr}, 64'd0);
        chk({tag, "_wdata"}, {56'd0, ctrl_data_wr}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        int s0;
        int r0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");

        // Full word write then read: ascending byte traffic 0x40..0x43.
        base = log_q.size();
        do_write(23'h10, 32'hA1B2C3D4, 4'hF);
        do_read("rd_full", 23'h10, 4'hF, 1'b0);
        chk("full_traffic_cnt", 64'(log_q.size() - base), 64'd8);
        for (int i = 0; i < 8; i++)
            chk("full_traffic", {38'd0, log_q[base + i]},
                {38'd0, (i < 4) ? 1'b1 : 1'b0, AD'(32'h40 + (i % 4))});

        // Partial write over all-ones.
        do_write(23'h20, 32'hFFFFFFFF, 4'hF);
        base = log_q.size();
        do_write(23'h20, 32'h11223344, 4'b0101);
        chk("part_wr_cnt", 64'(log_q.size() - base), 64'd2);
        chk("part_wr_b0", {38'd0, log_q[base]}, {38'd0, 1'b1, AD'(32'h80)});
        chk("part_wr_b2", {38'd0, log_q[base + 1]}, {38'd0, 1'b1, AD'(32'h82)});
        do_read("rd_part", 23'h20, 4'hF, 1'b0);
        chk("rd_part_const", {32'd0, resp_rdata}, 64'hFF22FF44);

        // Sparse read and empty write.
        base = log_q.size();
        do_read("rd_sparse", 23'h10, 4'b0110, 1'b0);
        chk("sparse_rd_cnt", 64'(log_q.size() - base), 64'd2);
        chk("sparse_rd_b1", {38'd0, log_q[base]}, {38'd0, 1'b0, AD'(32'h41)});
        chk("sparse_rd_b2", {38'd0, log_q[base + 1]}, {38'd0, 1'b0, AD'(32'h42)});
        base = log_q.size();
        send(1'b1, 23'h30, 32'hDEADBEEF, 4'b0000);
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        chk("be0_ready_cycles", {63'd0, n <= 2}, 64'd1);
        chk("be0_no_traffic", 64'(log_q.size() - base), 64'd0);

        // Controller busy while the first read byte is presented.
        s0 = stalls;
        busy_from = cyc + 1;
        busy_to = cyc + 8;
        do_read("rd_refresh", 23'h10, 4'hF, 1'b0);
        chk("refresh_stalled", {63'd0, stalls > s0}, 64'd1);
        chk("refresh_stable", 64'(unstable), 64'd0);

        // Silent controller: every byte times out.
        mute = 1'b1;
        base = log_q.size();
        do_read("rd_timeout", 23'h20, 4'hF, 1'b1);
        chk("timeout_rd_cnt", 64'(log_q.size() - base), 64'd4);
        mute = 1'b0;
        r0 = resp_cnt;
        inject_at = cyc + 2;
        repeat (6) @(negedge clk);
        chk("late_val_no_resp", 64'(resp_cnt - r0), 64'd0);
        chk("late_val_ready", {63'd0, req_ready}, 64'd1);
        do_read("rd_after_to", 23'h10, 4'hF, 1'b0);

        // Reset while waiting for read data.
        lat = 20;
        base = log_q.size();
        send(1'b0, 23'h10, 32'd0, 4'b0001);
        n = 0;
        while (log_q.size() == base && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("mid_reset");
        r0 = resp_cnt;
        repeat (25) @(negedge clk);
        chk("post_reset_no_resp", 64'(resp_cnt - r0), 64'd0);
        lat = 3;
        do_write(23'h44, 32'h5A6B7C8D, 4'hF);
        do_read("rd_post_reset", 23'h44, 4'hF, 1'b0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
